// File: rtl/pick_fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream seen by the pick FIFO reader.
// master = the reader, slave = the FIFO/downstream environment.
interface pick_fifo_stream_reader_if #(
   parameter int unsigned WIDTH = 8
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_dout;
   logic             fifo_read;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_last;

   modport master (
      input  fifo_empty, fifo_dout, out_ready,
      output fifo_read, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_dout, out_ready,
      input  fifo_read, out_valid, out_data, out_last
   );
endinterface

// File: rtl/pick_fifo_stream_reader.sv
// Drains a look-ahead FIFO into a 2-entry skid buffer and presents the words
// on a valid/ready stream, tagging every PKT_LEN-th word with out_last.
module pick_fifo_stream_reader #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PKT_LEN = 4
) (
   input  logic ck,
   input  logic reset,
   input  logic en_i,
   output logic idle_o,
   pick_fifo_stream_reader_if.master bus
);
   localparam int unsigned CNT_W = ($clog2(PKT_LEN + 1) < 1) ? 1 : $clog2(PKT_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(PKT_LEN - 1);

   logic [WIDTH-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
   logic             b0_last_q, b0_last_d, b1_last_q, b1_last_d;
   logic [1:0]       occ_q, occ_d;
   logic [CNT_W-1:0] pos_q, pos_d;
   logic             pop, acc, new_last;

   // Pop decision uses registered occupancy only, never out_ready.
   assign pop      = en_i & ~bus.fifo_empty & (occ_q != 2'd2);
   assign acc      = (occ_q != 2'd0) & bus.out_ready;
   assign new_last = (pos_q == LAST_POS);

   assign bus.fifo_read = pop;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_data  = b0_data_q;
   assign bus.out_last  = b0_last_q;
   assign idle_o        = ~en_i & (occ_q == 2'd0);

   always_comb begin
      b0_data_d = b0_data_q;
      b0_last_d = b0_last_q;
      b1_data_d = b1_data_q;
      b1_last_d = b1_last_q;
      occ_d     = occ_q;
      pos_d     = pos_q;

      if (pop) begin
         pos_d = new_last ? '0 : pos_q + CNT_W'(1);
      end

      // Skid buffer update by (pop, accept); b0 is always the head word.
      unique case ({pop, acc})
         2'b10: begin
            if (occ_q == 2'd0) begin
               b0_data_d = bus.fifo_dout;
               b0_last_d = new_last;
            end else begin
               b1_data_d = bus.fifo_dout;
               b1_last_d = new_last;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            b0_data_d = b1_data_q;
            b0_last_d = b1_last_q;
            occ_d     = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               b0_data_d = bus.fifo_dout;
               b0_last_d = new_last;
            end else begin
               b0_data_d = b1_data_q;
               b0_last_d = b1_last_q;
               b1_data_d = bus.fifo_dout;
               b1_last_d = new_last;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge ck or posedge reset) begin
      if (reset) begin
         b0_data_q <= '0;
         b0_last_q <= 1'b0;
         b1_data_q <= '0;
         b1_last_q <= 1'b0;
         occ_q     <= 2'd0;
         pos_q     <= '0;
      end else begin
         b0_data_q <= b0_data_d;
         b0_last_q <= b0_last_d;
         b1_data_q <= b1_data_d;
         b1_last_q <= b1_last_d;
         occ_q     <= occ_d;
         pos_q     <= pos_d;
      end
   end
endmodule

// File: tb/tb_pick_fifo_stream_reader.sv
// Scoreboard bench for pick_fifo_stream_reader: a PKT_LEN=4 and a PKT_LEN=1
// instance share one FIFO model; sel chooses which one is enabled and observed.
module tb_pick_fifo_stream_reader;
   typedef struct packed {
      logic [7:0] d;
      logic       l;
   } exp_t;

   logic       ck = 1'b0;
   logic       reset;
   logic       en, ready, sel;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic [7:0] fq[$];
   exp_t       sb[$];
   int         tests = 0, fails = 0;
   int         tbpos = 0, delivered = 0, pops = 0, lasts = 0;

   always #5 ck = ~ck;

   pick_fifo_stream_reader_if #(.WIDTH(8)) if4();
   pick_fifo_stream_reader_if #(.WIDTH(8)) if1();

   logic en4, en1, idle4, idle1;
   assign en4 = en & ~sel;
   assign en1 = en & sel;
   assign if4.fifo_empty = fifo_empty;
   assign if4.fifo_dout  = fifo_dout;
   assign if4.out_ready  = ready;
   assign if1.fifo_empty = fifo_empty;
   assign if1.fifo_dout  = fifo_dout;
   assign if1.out_ready  = ready;

   pick_fifo_stream_reader #(.WIDTH(8), .PKT_LEN(4)) dut4 (
      .ck(ck), .reset(reset), .en_i(en4), .idle_o(idle4), .bus(if4.master));
   pick_fifo_stream_reader #(.WIDTH(8), .PKT_LEN(1)) dut1 (
      .ck(ck), .reset(reset), .en_i(en1), .idle_o(idle1), .bus(if1.master));

   logic       rd, vld, lst, idl;
   logic [7:0] dat;
   assign rd  = sel ? if1.fifo_read : if4.fifo_read;
   assign vld = sel ? if1.out_valid : if4.out_valid;
   assign lst = sel ? if1.out_last  : if4.out_last;
   assign dat = sel ? if1.out_data  : if4.out_data;
   assign idl = sel ? idle1 : idle4;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_dout  = fifo_empty ? 8'h00 : fq[0];
   endtask

   // One clock: check outputs before the edge, then apply pop/accept to the models.
   task automatic step();
      int   plen;
      logic p, a, l;
      exp_t e;
      plen = sel ? 1 : 4;
      #1;
      p = rd;
      a = vld & ready;
      l = lst;
      check("fifo_read", 32'(p), 32'({en & ~fifo_empty & (sb.size() < 2)}));
      check("out_valid", 32'(vld), 32'({sb.size() != 0}));
      check("idle", 32'(idl), 32'({~en & (sb.size() == 0)}));
      if (vld && sb.size() != 0) begin
         check("out_data", 32'(dat), 32'(sb[0].d));
         check("out_last", 32'(lst), 32'(sb[0].l));
      end
      @(posedge ck);
      #1;
      if (a && sb.size() != 0) begin
         void'(sb.pop_front());
         delivered++;
         if (l) lasts++;
      end
      if (p) begin
         e.d = fifo_dout;
         e.l = (tbpos == plen - 1);
         tbpos = (tbpos == plen - 1) ? 0 : tbpos + 1;
         sb.push_back(e);
         if (fq.size() != 0) void'(fq.pop_front());
         pops++;
      end
      set_fifo();
      @(negedge ck);
   endtask

   task automatic drain(input int max, input bit toggle);
      int n = 0;
      while ((fq.size() != 0 && en) || sb.size() != 0) begin
         if (n >= max) begin
            check("drain_timeout", 32'd1, 32'd0);
            break;
         end
         if (toggle) ready = ~ready;
         step();
         n++;
      end
   endtask

   task automatic new_test(input logic s);
      en = 1'b0;
      ready = 1'b0;
      @(negedge ck);
      reset = 1'b1;
      @(negedge ck);
      sel = s;
      reset = 1'b0;
      sb.delete();
      fq.delete();
      set_fifo();
      tbpos = 0; delivered = 0; pops = 0; lasts = 0;
   endtask

   task automatic load(input int n, input logic [7:0] first, input logic [7:0] inc);
      for (int i = 0; i < n; i++) fq.push_back(8'(first + 8'(i) * inc));
      set_fifo();
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; ready = 1'b0; sel = 1'b0;
      set_fifo();
      repeat (2) @(negedge ck);
      #1;
      check("rst_valid", 32'(vld), 32'd0);
      check("rst_data", 32'(dat), 32'd0);
      check("rst_last", 32'(lst), 32'd0);
      check("rst_idle", 32'(idl), 32'd1);
      check("rst_read", 32'(rd), 32'd0);

      // Streaming at full rate
      new_test(1'b0);
      load(5, 8'h11, 8'h11);
      en = 1'b1; ready = 1'b1;
      drain(30, 1'b0);
      check("t1_pops", pops, 5);
      check("t1_delivered", delivered, 5);
      check("t1_lasts", lasts, 1);

      // Backpressure: buffer fills to two, head stays stable
      new_test(1'b0);
      load(5, 8'h11, 8'h11);
      en = 1'b1; ready = 1'b0;
      repeat (6) step();
      check("t2_pops", pops, 2);
      check("t2_occ", sb.size(), 2);
      check("t2_head", 32'(dat), 32'h11);
      ready = 1'b1;
      drain(30, 1'b0);
      check("t2_delivered", delivered, 5);

      // Toggling ready on a 10-word stream
      new_test(1'b0);
      load(10, 8'h01, 8'h01);
      en = 1'b1; ready = 1'b0;
      drain(60, 1'b1);
      check("t3_delivered", delivered, 10);
      check("t3_lasts", lasts, 2);

      // en dropped after two pops, packet resumes mid-way
      new_test(1'b0);
      load(5, 8'h11, 8'h11);
      en = 1'b1; ready = 1'b1;
      for (int i = 0; i < 10 && pops < 2; i++) step();
      en = 1'b0;
      for (int i = 0; i < 5 && sb.size() != 0; i++) step();
      step();
      #1;
      check("t4_valid_off", 32'(vld), 32'd0);
      check("t4_idle", 32'(idl), 32'd1);
      check("t4_delivered", delivered, 2);
      check("t4_fifo_left", fq.size(), 3);
      @(negedge ck);
      en = 1'b1;
      drain(30, 1'b0);
      check("t4_total", delivered, 5);
      check("t4_lasts", lasts, 1);

      // Async reset while buffer is full mid-packet
      new_test(1'b0);
      load(8, 8'h11, 8'h11);
      en = 1'b1; ready = 1'b0;
      for (int i = 0; i < 10 && sb.size() < 2; i++) step();
      check("t5_occ", sb.size(), 2);
      #2 reset = 1'b1;
      #1;
      check("t5_async_valid", 32'(vld), 32'd0);
      sb.delete();
      tbpos = 0; delivered = 0; lasts = 0;
      @(negedge ck);
      reset = 1'b0;
      ready = 1'b1;
      drain(40, 1'b0);
      check("t5_delivered", delivered, 6);
      check("t5_lasts", lasts, 1);

      // PKT_LEN=1: every word is last
      new_test(1'b1);
      load(3, 8'hA1, 8'h01);
      en = 1'b1; ready = 1'b1;
      drain(30, 1'b0);
      check("t6_delivered", delivered, 3);
      check("t6_lasts", lasts, 3);

      // Empty FIFO never pops or produces data
      new_test(1'b1);
      en = 1'b1; ready = 1'b1;
      repeat (10) step();
      check("t7_pops", pops, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
